undo_stack: RTL and testbench

- Parametrised undo stack for the pipelined AXA core.
- Replaces the single-pointer undo file with a LIFO buffer that has:
  - two independent push channels per cycle (destination value and PC);
  - one pop channel;
  - a registered random-read port, indexed from the top, serving SRC_UNDO operand reads;
  - selectable overflow policy: reject or discard-oldest.
- Sits beside the register file. Pushes come from the ALU/write-back stages; reads and pops come from register read.

---
 rtl/undo_stack.sv | 135 +++++++++++++
 tb/tb_undo_stack.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/undo_stack.sv
// rtl/undo_stack.sv - LIFO undo stack with dual push, pop, and registered top-relative read
//
// Ports:
//   clk, reset (async active-low)
//   push_a_valid/data/tag : push channel A (destination value), applied after pop
//   push_b_valid/data/tag : push channel B (PC), applied after A, ends on top
//   pop_req               : pop top entry; pop_valid/pop_data/pop_tag one cycle later
//   rd_idx                : offset from top; rd_hit/rd_data registered one cycle later
//   count, full, empty    : occupancy status
//   overflow, underflow   : sticky error flags, cleared by clr_err
module undo_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int TAG_W = 1,
    parameter int WRAP  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_a_valid,
    input  logic [WIDTH-1:0]           push_a_data,
    input  logic [TAG_W-1:0]           push_a_tag,
    input  logic                       push_b_valid,
    input  logic [WIDTH-1:0]           push_b_data,
    input  logic [TAG_W-1:0]           push_b_tag,
    input  logic                       pop_req,
    output logic                       pop_valid,
    output logic [WIDTH-1:0]           pop_data,
    output logic [TAG_W-1:0]           pop_tag,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       rd_hit,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam bit WRAP_EN = (WRAP != 0);

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];

    // top points at the most recent entry; the oldest sits at top-count+1,
    // so when full the slot after top is exactly the oldest entry.
    logic [PW-1:0] top;

    logic          pop_ok;
    logic [PW-1:0] top_p, top_a, top_b, addr_a, addr_b;
    logic [CW-1:0] cnt_p, cnt_a, cnt_b;
    logic          room_a, room_b, we_a, we_b, ovf_evt;
    logic          rd_in_range;

    always_comb begin
        pop_ok = pop_req && (count != '0);
        top_p  = pop_ok ? top - PW'(1) : top;
        cnt_p  = pop_ok ? count - CW'(1) : count;

        // Channel A sees post-pop occupancy.
        room_a = (cnt_p != DEPTH_C);
        addr_a = top_p + PW'(1);
        we_a   = push_a_valid && (room_a || WRAP_EN);
        top_a  = we_a ? addr_a : top_p;
        cnt_a  = (push_a_valid && room_a) ? cnt_p + CW'(1) : cnt_p;

        // Channel B sees occupancy after A.
        room_b = (cnt_a != DEPTH_C);
        addr_b = top_a + PW'(1);
        we_b   = push_b_valid && (room_b || WRAP_EN);
        top_b  = we_b ? addr_b : top_a;
        cnt_b  = (push_b_valid && room_b) ? cnt_a + CW'(1) : cnt_a;

        // A push without room is either dropped or overwrites the oldest.
        ovf_evt = (push_a_valid && !room_a) || (push_b_valid && !room_b);

        rd_in_range = ({1'b0, rd_idx} < count);
    end

    // Storage has no reset; entries beyond count are never exposed.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_data[addr_a] <= push_a_data;
            mem_tag[addr_a]  <= push_a_tag;
        end
        if (we_b) begin
            mem_data[addr_b] <= push_b_data;
            mem_tag[addr_b]  <= push_b_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top       <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            pop_tag   <= '0;
            rd_hit    <= 1'b0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            top       <= top_b;
            count     <= cnt_b;
            pop_valid <= pop_ok;
            if (pop_ok) begin
                pop_data <= mem_data[top];
                pop_tag  <= mem_tag[top];
            end

            // Read port samples pre-edge contents.
            rd_hit  <= rd_in_range;
            rd_data <= rd_in_range ? mem_data[top - rd_idx] : '0;

            // clr_err wins over a same-cycle set.
            if (clr_err)
                overflow <= 1'b0;
            else if (ovf_evt)
                overflow <= 1'b1;

            if (clr_err)
                underflow <= 1'b0;
            else if (pop_req && (count == '0))
                underflow <= 1'b1;
        end
    end

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: tb/tb_undo_stack.sv
// tb/tb_undo_stack.sv - directed table-driven bench for undo_stack (DEPTH=4, reject and wrap policies)
module tb_undo_stack;

    logic        clk;
    logic        reset;
    logic        push_a_valid, push_b_valid, pop_req, clr_err;
    logic [15:0] push_a_data, push_b_data;
    logic        push_a_tag, push_b_tag;
    logic [1:0]  rd_idx;

    logic        pv0, pv1, pt0, pt1, hit0, hit1, full0, full1, emp0, emp1;
    logic        ovf0, ovf1, udf0, udf1;
    logic [15:0] pd0, pd1, rd0, rd1;
    logic [2:0]  cnt0, cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    undo_stack #(.WIDTH(16), .DEPTH(4), .TAG_W(1), .WRAP(0)) dut_rej (
        .clk(clk), .reset(reset),
        .push_a_valid(push_a_valid), .push_a_data(push_a_data), .push_a_tag(push_a_tag),
        .push_b_valid(push_b_valid), .push_b_data(push_b_data), .push_b_tag(push_b_tag),
        .pop_req(pop_req), .pop_valid(pv0), .pop_data(pd0), .pop_tag(pt0),
        .rd_idx(rd_idx), .rd_hit(hit0), .rd_data(rd0),
        .count(cnt0), .full(full0), .empty(emp0),
        .overflow(ovf0), .underflow(udf0), .clr_err(clr_err)
    );

    undo_stack #(.WIDTH(16), .DEPTH(4), .TAG_W(1), .WRAP(1)) dut_wrap (
        .clk(clk), .reset(reset),
        .push_a_valid(push_a_valid), .push_a_data(push_a_data), .push_a_tag(push_a_tag),
        .push_b_valid(push_b_valid), .push_b_data(push_b_data), .push_b_tag(push_b_tag),
        .pop_req(pop_req), .pop_valid(pv1), .pop_data(pd1), .pop_tag(pt1),
        .rd_idx(rd_idx), .rd_hit(hit1), .rd_data(rd1),
        .count(cnt1), .full(full1), .empty(emp1),
        .overflow(ovf1), .underflow(udf1), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av; logic [15:0] ad; logic at;
        logic        bv; logic [15:0] bd; logic bt;
        logic        pop; logic [1:0] idx; logic clr;
        logic [2:0]  e_cnt; logic e_pv; logic [15:0] e_pd; logic e_pt;
        logic        e_hit; logic [15:0] e_rd; logic e_ovf; logic e_udf;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic av, input logic [15:0] ad, input logic bv,
                         input logic [15:0] bd, input logic pop, input logic [1:0] idx,
                         input logic clr);
        push_a_valid = av; push_a_data = ad; push_a_tag = 1'b0;
        push_b_valid = bv; push_b_data = bd; push_b_tag = 1'b0;
        pop_req = pop; rd_idx = idx; clr_err = clr;
    endtask

    task automatic push1(input logic [15:0] d);
        drive(1'b1, d, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    logic [15:0] exp_rej [4];
    logic [15:0] exp_wrap[4];

    initial begin
        //            av ad        at bv bd        bt pop idx clr  cnt pv pd        pt hit rd        ovf udf
        vecs[0]  = '{1, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 0,   1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0};
        vecs[1]  = '{0, 16'h0000, 0, 1, 16'h0042, 1, 0, 0, 0,   2, 0, 16'h0000, 0, 1, 16'h1234, 0, 0};
        vecs[2]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0,   1, 1, 16'h0042, 1, 1, 16'h1234, 0, 0};
        vecs[3]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0,   0, 1, 16'h1234, 0, 1, 16'h1234, 0, 0};
        vecs[4]  = '{1, 16'hAAAA, 0, 1, 16'hBBBB, 1, 0, 0, 0,   2, 0, 16'h0000, 0, 0, 16'h0000, 0, 0};
        vecs[5]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,   2, 0, 16'h0000, 0, 1, 16'hBBBB, 0, 0};
        vecs[6]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0,   2, 0, 16'h0000, 0, 1, 16'hAAAA, 0, 0};
        vecs[7]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 0,   2, 0, 16'h0000, 0, 0, 16'h0000, 0, 0};
        vecs[8]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 3, 0,   1, 1, 16'hBBBB, 1, 0, 16'h0000, 0, 0};
        vecs[9]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0,   0, 1, 16'hAAAA, 0, 1, 16'hAAAA, 0, 0};
        vecs[10] = '{1, 16'h7777, 0, 0, 16'h0000, 0, 1, 0, 0,   1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1};
        vecs[11] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,   1, 0, 16'h0000, 0, 1, 16'h7777, 0, 1};
        vecs[12] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1,   0, 1, 16'h7777, 0, 1, 16'h7777, 0, 0};
        vecs[13] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1,   0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0};

        do_reset();

        chk("reset count",     {29'd0, cnt0}, 32'd0);
        chk("reset empty",     {31'd0, emp0}, 32'd1);
        chk("reset full",      {31'd0, full0}, 32'd0);
        chk("reset pop_valid", {31'd0, pv0},  32'd0);
        chk("reset rd_hit",    {31'd0, hit0}, 32'd0);
        chk("reset flags",     {30'd0, ovf0, udf0}, 32'd0);
        chk("reset wrap count",{29'd0, cnt1}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            push_a_valid = vecs[i].av; push_a_data = vecs[i].ad; push_a_tag = vecs[i].at;
            push_b_valid = vecs[i].bv; push_b_data = vecs[i].bd; push_b_tag = vecs[i].bt;
            pop_req = vecs[i].pop; rd_idx = vecs[i].idx; clr_err = vecs[i].clr;
            tick();
            chk($sformatf("v%0d count", i),  {29'd0, cnt0}, {29'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d wcount", i), {29'd0, cnt1}, {29'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d empty", i),  {31'd0, emp0}, {31'd0, vecs[i].e_cnt == 3'd0});
            chk($sformatf("v%0d pop_valid", i), {31'd0, pv0}, {31'd0, vecs[i].e_pv});
            chk($sformatf("v%0d wpop_valid", i), {31'd0, pv1}, {31'd0, vecs[i].e_pv});
            if (vecs[i].e_pv) begin
                chk($sformatf("v%0d pop_data", i), {16'd0, pd0}, {16'd0, vecs[i].e_pd});
                chk($sformatf("v%0d pop_tag", i),  {31'd0, pt0}, {31'd0, vecs[i].e_pt});
                chk($sformatf("v%0d wpop_data", i), {16'd0, pd1}, {16'd0, vecs[i].e_pd});
            end
            chk($sformatf("v%0d rd_hit", i),  {31'd0, hit0}, {31'd0, vecs[i].e_hit});
            chk($sformatf("v%0d rd_data", i), {16'd0, rd0},  {16'd0, vecs[i].e_rd});
            chk($sformatf("v%0d wrd_data", i), {16'd0, rd1}, {16'd0, vecs[i].e_rd});
            chk($sformatf("v%0d overflow", i),  {31'd0, ovf0}, {31'd0, vecs[i].e_ovf});
            chk($sformatf("v%0d underflow", i), {31'd0, udf0}, {31'd0, vecs[i].e_udf});
        end

        // Dual push into a single free slot.
        do_reset();
        push1(16'd1); push1(16'd2); push1(16'd3);
        drive(1'b1, 16'd4, 1'b1, 16'd5, 1'b0, 2'd0, 1'b0);
        tick();
        chk("dual count rej",  {29'd0, cnt0}, 32'd4);
        chk("dual count wrap", {29'd0, cnt1}, 32'd4);
        chk("dual ovf rej",    {31'd0, ovf0}, 32'd1);
        chk("dual ovf wrap",   {31'd0, ovf1}, 32'd1);
        chk("dual full rej",   {31'd0, full0}, 32'd1);
        exp_rej  = '{16'd4, 16'd3, 16'd2, 16'd1};
        exp_wrap = '{16'd5, 16'd4, 16'd3, 16'd2};
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 2'd0, 1'b0);
            tick();
            if (k == 0) begin
                chk("dual top rej",  {16'd0, rd0}, 32'd4);
                chk("dual top wrap", {16'd0, rd1}, 32'd5);
            end
            chk($sformatf("dual pop%0d rej", k),  {15'd0, pv0, pd0}, {15'd0, 1'b1, exp_rej[k]});
            chk($sformatf("dual pop%0d wrap", k), {15'd0, pv1, pd1}, {15'd0, 1'b1, exp_wrap[k]});
        end
        chk("dual drained", {29'd0, cnt0}, 32'd0);

        // Single pushes past full, then a dual push while full.
        do_reset();
        for (int v = 1; v <= 6; v++) push1(16'(v));
        chk("six count rej",  {29'd0, cnt0}, 32'd4);
        chk("six count wrap", {29'd0, cnt1}, 32'd4);
        chk("six ovf rej",    {31'd0, ovf0}, 32'd1);
        chk("six ovf wrap",   {31'd0, ovf1}, 32'd1);
        drive(1'b1, 16'd7, 1'b1, 16'd8, 1'b0, 2'd0, 1'b0);
        tick();
        chk("full dual count wrap", {29'd0, cnt1}, 32'd4);
        exp_rej  = '{16'd4, 16'd3, 16'd2, 16'd1};
        exp_wrap = '{16'd8, 16'd7, 16'd6, 16'd5};
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 2'd0, 1'b0);
            tick();
            chk($sformatf("wrap pop%0d rej", k),  {15'd0, pv0, pd0}, {15'd0, 1'b1, exp_rej[k]});
            chk($sformatf("wrap pop%0d wrap", k), {15'd0, pv1, pd1}, {15'd0, 1'b1, exp_wrap[k]});
        end

        // Pop plus push while full, then asynchronous reset mid-operation.
        do_reset();
        for (int v = 1; v <= 4; v++) push1(16'(v));
        chk("prefull ovf", {30'd0, ovf0, ovf1}, 32'd0);
        drive(1'b1, 16'h9999, 1'b0, 16'h0, 1'b1, 2'd0, 1'b0);
        tick();
        chk("pp pop rej",   {15'd0, pv0, pd0}, {15'd0, 1'b1, 16'd4});
        chk("pp pop wrap",  {15'd0, pv1, pd1}, {15'd0, 1'b1, 16'd4});
        chk("pp count",     {26'd0, cnt0, cnt1}, {26'd0, 3'd4, 3'd4});
        chk("pp ovf",       {30'd0, ovf0, ovf1}, 32'd0);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        tick();
        chk("pp top rej",   {15'd0, hit0, rd0}, {15'd0, 1'b1, 16'h9999});
        chk("pp top wrap",  {15'd0, hit1, rd1}, {15'd0, 1'b1, 16'h9999});
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 2'd1, 1'b0);
        tick();
        chk("pre-reset pop", {15'd0, pv0, pd0}, {15'd0, 1'b1, 16'h9999});
        #2;
        reset = 1'b0;
        #1;
        chk("async count",     {29'd0, cnt0}, 32'd0);
        chk("async empty",     {31'd0, emp0}, 32'd1);
        chk("async pop_valid", {30'd0, pv0, pv1}, 32'd0);
        chk("async rd_hit",    {30'd0, hit0, hit1}, 32'd0);
        chk("async pop_data",  {16'd0, pd0}, 32'd0);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk("post-reset empty", {30'd0, emp0, emp1}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
